// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point add/sub normalise stage.
// Default widths describe IEEE-754 single precision; the flag indices give
// the bit positions inside the 3-bit {overflow, underflow, inexact} vector.
package fp_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int MW_DEF    = MAN_W_DEF + 5;
    localparam int BIAS_DEF  = (1 << (EXP_W_DEF - 1)) - 1;

    localparam logic [EXP_W_DEF-1:0] EXP_ALL_ONES_DEF = '1;

    localparam int FLAGS_W  = 3;
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    // Classification carried from the normalise stage to the round/pack stage.
    typedef enum logic [1:0] {
        CLS_NORM    = 2'd0,
        CLS_ZERO    = 2'd1,
        CLS_SPECIAL = 2'd2
    } fp_class_t;

    // Packed result at the default widths.
    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF-1:0] frac;
    } fp_result_t;

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter. count = number of zeros above the
// highest set bit; an all-zero input returns W.
module fp_lzc #(
    parameter int W  = 27,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  bits_in,
    output logic [CW-1:0] count
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        count = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (bits_in[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_normalize_pipe.sv
// Two-stage normalise / round / pack stage for the FP add/sub datapath.
//   Stage 1: classify, normalise (1-bit right shift on carry, or left shift
//            by the leading-zero count), signed exponent of EXP_W+2 bits.
//   Stage 2: round-to-nearest-even, overflow/underflow handling, pack.
// Optional feature macro: FPNORM_DENORM_EN -- when defined, tiny results are
// produced as denormals (left shift clamped to e-1); when undefined, tiny
// results flush to signed zero with underflow and inexact set.
module fp_addsub_normalize_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = EXP_W_DEF,
    parameter  int MAN_W = MAN_W_DEF,
    localparam int MW    = MAN_W + 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MW-1:0]          in_m,
    input  logic [EXP_W-1:0]       in_e,
    input  logic                   in_s,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_z,
    output logic [FLAGS_W-1:0]     out_flags
);

    // Handshake: a beat moves across an interface on a rising edge where
    // valid and ready are both high. Stage 2 loads when it is empty or its
    // content is being taken downstream; stage 1 loads when it is empty or
    // stage 2 is loading. in_ready is therefore !v1 | !v2 | out_ready, and a
    // stalled output holds out_z/out_flags unchanged.

    localparam int NW = MW - 1;          // hidden + frac + G/R/S
    localparam int FW = MAN_W + 3;       // frac + G/R/S (hidden implied)
    localparam int EW = EXP_W + 2;       // signed internal exponent
    localparam int CW = $clog2(NW + 1);
    localparam int ZW = 1 + EXP_W + MAN_W;

    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);

    logic load1, load2;

    // Stage 1 registers
    logic                   v1;
    logic                   s1;
    logic signed [EW-1:0]   e1;
    logic [FW-1:0]          n1;
    fp_class_t              cls1;

    // Stage 2 registers
    logic                   v2;
    logic [ZW-1:0]          z_q;
    logic [FLAGS_W-1:0]     f_q;

    // Stage 1 combinational signals
    logic [CW-1:0]          lz;
    logic [CW-1:0]          sh_amt;
    logic signed [EW-1:0]   e_in;
    logic signed [EW-1:0]   lz_ext;
    logic signed [EW-1:0]   e_nxt;
    logic [FW-1:0]          n_nxt;
    fp_class_t              cls_nxt;

    // Stage 2 combinational signals
    logic [MAN_W-1:0]       frac1;
    logic                   rnd_lsb, rnd_g, rnd_r, rnd_s;
    logic                   rnd_up, inexact;
    logic [MAN_W:0]         frac_inc;
    logic [MAN_W-1:0]       frac_rnd;
    logic signed [EW-1:0]   e_rnd;
    logic [ZW-1:0]          z_nxt;
    logic [FLAGS_W-1:0]     f_nxt;

`ifdef FPNORM_DENORM_EN
    logic                   den_nxt;
    logic                   den1;
    logic [EXP_W-1:0]       e_m1;
    assign e_m1 = in_e - 1'b1;
`endif

    assign load2     = !v2 || out_ready;
    assign load1     = !v1 || load2;
    assign in_ready  = load1;
    assign out_valid = v2;
    assign out_z     = z_q;
    assign out_flags = f_q;

    fp_lzc #(.W(NW), .CW(CW)) u_lzc (
        .bits_in (in_m[NW-1:0]),
        .count   (lz)
    );

    assign e_in   = signed'({2'b00, in_e});
    assign lz_ext = signed'(EW'(lz));

    // Stage 1: classify the beat and normalise mantissa and exponent.
    // The hidden bit is dropped from the stored mantissa; the left shift is
    // applied to the field below the hidden position so the leading one
    // falls off the top. An input exponent of zero is taken as already at
    // the denormal scale, so no left shift is applied in that case.
    always_comb begin
        cls_nxt = CLS_NORM;
        e_nxt   = E_ZERO;
        n_nxt   = '0;
        sh_amt  = lz;
`ifdef FPNORM_DENORM_EN
        den_nxt = 1'b0;
`endif
        if (in_m == '0) begin
            cls_nxt = CLS_ZERO;
        end else if (in_e == '1) begin
            cls_nxt = CLS_SPECIAL;
            n_nxt   = in_m[FW-1:0];
        end else if (in_m[MW-1]) begin
            n_nxt = {in_m[MW-2:2], in_m[1] | in_m[0]};
            e_nxt = e_in + E_ONE;
        end else begin
`ifdef FPNORM_DENORM_EN
            if ((e_in - lz_ext) < E_ONE) begin
                den_nxt = 1'b1;
                e_nxt   = E_ZERO;
                sh_amt  = (in_e == '0) ? '0 : e_m1[CW-1:0];
            end else begin
                e_nxt = e_in - lz_ext;
            end
`else
            e_nxt = e_in - lz_ext;
`endif
            n_nxt = in_m[FW-1:0] << sh_amt;
        end
    end

    // Stage 1 register: accepts a new beat whenever stage 1 can advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            s1   <= 1'b0;
            e1   <= E_ZERO;
            n1   <= '0;
            cls1 <= CLS_NORM;
`ifdef FPNORM_DENORM_EN
            den1 <= 1'b0;
`endif
        end else if (load1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1   <= in_s;
                e1   <= e_nxt;
                n1   <= n_nxt;
                cls1 <= cls_nxt;
`ifdef FPNORM_DENORM_EN
                den1 <= den_nxt;
`endif
            end
        end
    end

    assign frac1    = n1[FW-1:3];
    assign rnd_lsb  = n1[3];
    assign rnd_g    = n1[2];
    assign rnd_r    = n1[1];
    assign rnd_s    = n1[0];
    assign rnd_up   = rnd_g & (rnd_lsb | rnd_r | rnd_s);
    assign inexact  = rnd_g | rnd_r | rnd_s;
    assign frac_inc = {1'b0, frac1} + {{MAN_W{1'b0}}, rnd_up};
    assign frac_rnd = frac_inc[MAN_W] ? '0 : frac_inc[MAN_W-1:0];
    assign e_rnd    = frac_inc[MAN_W] ? (e1 + E_ONE) : e1;

    // Stage 2: round to nearest even, detect overflow/underflow, pack.
    always_comb begin
        z_nxt = '0;
        f_nxt = '0;
        case (cls1)
            CLS_ZERO: begin
                z_nxt[ZW-1] = s1;
            end
            CLS_SPECIAL: begin
                z_nxt = {s1, {EXP_W{1'b1}}, frac1};
            end
            default: begin
                if (e_rnd >= E_MAX) begin
                    z_nxt           = {s1, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    f_nxt[FLAG_OVF] = 1'b1;
                    f_nxt[FLAG_INX] = 1'b1;
                end else if (e_rnd < E_ONE) begin
`ifdef FPNORM_DENORM_EN
                    z_nxt           = {s1, {EXP_W{1'b0}}, frac_rnd};
                    f_nxt[FLAG_UNF] = den1 & inexact;
                    f_nxt[FLAG_INX] = inexact;
`else
                    z_nxt[ZW-1]     = s1;
                    f_nxt[FLAG_UNF] = 1'b1;
                    f_nxt[FLAG_INX] = 1'b1;
`endif
                end else begin
                    z_nxt           = {s1, e_rnd[EXP_W-1:0], frac_rnd};
                    f_nxt[FLAG_INX] = inexact;
`ifdef FPNORM_DENORM_EN
                    f_nxt[FLAG_UNF] = den1 & inexact;
`endif
                end
            end
        endcase
    end

    // Stage 2 register: output word, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2  <= 1'b0;
            z_q <= '0;
            f_q <= '0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                z_q <= z_nxt;
                f_q <= f_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_normalize_pipe.sv
// Self-checking bench for fp_addsub_normalize_pipe at default widths.
// Directed vector table, latency/backpressure/reset sequences and random
// beats under random out_ready, all checked through an expected-value queue.
module tb_fp_addsub_normalize_pipe;
    import fp_pkg::*;

    localparam int MW = 28;
    localparam int W  = 35;   // {out_z, out_flags}

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] in_m;
    logic [7:0]    in_e;
    logic          in_s;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_z;
    logic [2:0]    out_flags;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_head;

    typedef struct packed {
        logic [27:0] m;
        logic [7:0]  e;
        logic        s;
        logic [31:0] z;
        logic [2:0]  f;
    } vec_t;

    vec_t vecs[12];
    bit   rand_done = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    fp_addsub_normalize_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_m      (in_m),
        .in_e      (in_e),
        .in_s      (in_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_flags (out_flags)
    );

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: exact value m * 2^(e - bias - 26), rounded to 24
    // significant bits by comparing the discarded remainder against half.
    function automatic logic [W-1:0] model(input logic [27:0] m, input logic [7:0] e, input logic s);
        longint     mm, k, rem, half, one;
        int         p, ex, sh;
        logic       inx;
        fp_result_t r;
        one = 1;
        mm  = longint'(m);
        if (m == 28'd0) return {s, 31'd0, 3'b000};
        if (e == 8'hFF) return {s, 8'hFF, m[25:3], 3'b000};
        p = 27;
        while (m[p] == 1'b0) p--;
        ex = int'(e) + p - 26;
        if (p > 23) begin
            sh   = p - 23;
            k    = mm >> sh;
            rem  = mm & ((one << sh) - 1);
            half = one << (sh - 1);
            if (rem > half || (rem == half && k[0])) k = k + 1;
        end else begin
            k   = mm << (23 - p);
            rem = 0;
        end
        inx = (rem != 0);
        if (k == (one << 24)) begin
            k  = one << 23;
            ex = ex + 1;
        end
        if (ex >= 255) return {s, 8'hFF, 23'd0, 3'b101};
        if (ex < 1) return {s, 31'd0, 3'b011};
        r.sign = s;
        r.exp  = ex[7:0];
        r.frac = k[22:0];
        return {r, 2'b00, inx};
    endfunction

    // ---------------- scoreboard: output monitor ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h, expected no beat (t=%0t)", {out_z, out_flags}, $time);
            end else begin
                exp_head = exp_q.pop_front();
                check("output_beat", 64'({out_z, out_flags}), 64'(exp_head));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic send(input logic [27:0] m, input logic [7:0] e, input logic s, input logic [W-1:0] expv);
        int budget = 200;
        bit done   = 1'b0;
        in_valid = 1'b1;
        in_m     = m;
        in_e     = e;
        in_s     = s;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                done = 1'b1;
            end else begin
                budget--;
                if (budget == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        int accepted;
        int idx;
        logic [27:0] rm;
        logic [7:0]  re;
        logic        rs;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_m      = '0;
        in_e      = '0;
        in_s      = 1'b0;
        out_ready = 1'b0;

        vecs[0]  = '{m: 28'h8000000, e: 8'h7F, s: 1'b0, z: 32'h40000000, f: 3'b000};
        vecs[1]  = '{m: 28'h0100000, e: 8'h85, s: 1'b0, z: 32'h3F800000, f: 3'b000};
        vecs[2]  = '{m: 28'h400000C, e: 8'h7F, s: 1'b0, z: 32'h3F800002, f: 3'b001};
        vecs[3]  = '{m: 28'h4000004, e: 8'h7F, s: 1'b0, z: 32'h3F800000, f: 3'b001};
        vecs[4]  = '{m: 28'h7FFFFFC, e: 8'h7F, s: 1'b0, z: 32'h40000000, f: 3'b001};
        vecs[5]  = '{m: 28'h8000000, e: 8'hFE, s: 1'b0, z: 32'h7F800000, f: 3'b101};
`ifdef FPNORM_DENORM_EN
        vecs[6]  = '{m: 28'h0000008, e: 8'h10, s: 1'b0, z: 32'h00008000, f: 3'b000};
`else
        vecs[6]  = '{m: 28'h0000008, e: 8'h10, s: 1'b0, z: 32'h00000000, f: 3'b011};
`endif
        vecs[7]  = '{m: 28'h0000000, e: 8'h55, s: 1'b1, z: 32'h80000000, f: 3'b000};
        vecs[8]  = '{m: 28'h4400018, e: 8'hFF, s: 1'b1, z: 32'hFF880003, f: 3'b000};
        vecs[9]  = '{m: 28'h4000000, e: 8'h80, s: 1'b1, z: 32'hC0000000, f: 3'b000};
        vecs[10] = '{m: 28'h8000001, e: 8'h7F, s: 1'b0, z: 32'h40000000, f: 3'b001};
        vecs[11] = '{m: 28'h8000018, e: 8'h7F, s: 1'b0, z: 32'h40000002, f: 3'b001};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_z", 64'(out_z), 64'd0);
        check("reset_out_flags", 64'(out_flags), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // ---- two-cycle latency ----
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_m     = vecs[0].m;
        in_e     = vecs[0].e;
        in_s     = vecs[0].s;
        @(negedge clk);
        check("lat_in_ready", 64'(in_ready), 64'd1);
        exp_q.push_back({vecs[0].z, vecs[0].f});
        check("lat_cycle0_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_cycle2_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_drain();

        // ---- directed vector table, back to back ----
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].m, vecs[i].e, vecs[i].s, {vecs[i].z, vecs[i].f});
        end
        wait_drain();

        // ---- backpressure: 5 stalled cycles while offering 3 beats ----
        out_ready = 1'b0;
        accepted  = 0;
        idx       = 2;
        in_valid  = 1'b1;
        in_m      = vecs[idx].m;
        in_e      = vecs[idx].e;
        in_s      = vecs[idx].s;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
                check("bp_output_stable", 64'({out_z, out_flags}), 64'({vecs[2].z, vecs[2].f}));
            end
            if (in_ready) begin
                exp_q.push_back({vecs[idx].z, vecs[idx].f});
                accepted++;
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx <= 4) begin
                in_m = vecs[idx].m;
                in_e = vecs[idx].e;
                in_s = vecs[idx].s;
            end
        end
        @(negedge clk);
        check("bp_accepted_count", 64'(accepted), 64'd2);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid_held", 64'(out_valid), 64'd1);
        check("bp_out_z_held", 64'(out_z), 64'(vecs[2].z));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        if (in_ready) exp_q.push_back({vecs[4].z, vecs[4].f});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // ---- reset while stalled with beats in flight ----
        out_ready = 1'b0;
        send(vecs[0].m, vecs[0].e, vecs[0].s, {vecs[0].z, vecs[0].f});
        send(vecs[1].m, vecs[1].e, vecs[1].s, {vecs[1].z, vecs[1].f});
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_out_z", 64'(out_z), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_no_stale_beat", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // ---- random beats under random backpressure ----
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            rm = 28'($urandom()) >> $urandom_range(0, 27);
`ifdef FPNORM_DENORM_EN
            re = 8'($urandom_range(27, 255));
`else
            re = 8'($urandom_range(0, 255));
`endif
            rs = 1'($urandom_range(0, 1));
            send(rm, re, rs, model(rm, re, rs));
        end
        rand_done = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
